dcache_ctrl: RTL and testbench

- Data-side responder for the MEM stage: consumes the M-stage memory controls (memread_M, memwrite_M, load_store_M) and the ALU address/store data; returns extended load data and the `miss` stall that freezes the pipeline.
- Direct-mapped, one-word-line, write-through, no-write-allocate cache in front of a slow word-wide memory port with a valid/ready handshake.

---
 rtl/dcache_ctrl.sv | 167 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, one-word-line, write-through / no-write-allocate data cache
// for the MEM stage, fronting a slow word-wide valid/ready memory port.
module dcache_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memread,
    input  logic                  memwrite,
    input  logic [2:0]            load_store,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  miss,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

    state_t state, state_nxt;

    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] data_mem [LINES];

    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [3:0]            lat_wstrb;

    logic [1:0]            offset;
    logic [INDEX_BITS-1:0] index, lat_index;
    logic [TAG_BITS-1:0]   tag, lat_tag;
    logic                  hit, wr_hit;
    logic [DATA_WIDTH-1:0] line_word, load_data, st_data, merged;
    logic [3:0]            st_strb;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic                  start_access;

    assign offset    = addr[1:0];
    assign index     = addr[INDEX_BITS+1:2];
    assign tag       = addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign lat_index = lat_addr[INDEX_BITS+1:2];
    assign lat_tag   = lat_addr[ADDR_WIDTH-1:INDEX_BITS+2];

    assign line_word = data_mem[index];
    assign hit       = valid_q[index] && (tag_mem[index] == tag);
    assign wr_hit    = valid_q[lat_index] && (tag_mem[lat_index] == lat_tag);

    assign sel_byte  = line_word[{offset, 3'b000} +: 8];
    assign sel_half  = offset[1] ? line_word[31:16] : line_word[15:0];

    always_comb begin
        case (load_store)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_data = {24'h0, sel_byte};
            3'b010:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b011:  load_data = {16'h0, sel_half};
            default: load_data = line_word;
        endcase
    end

    // Stores replicate the narrow datum across lanes; the strobe picks the lane.
    always_comb begin
        st_data = wdata;
        st_strb = 4'b1111;
        case (load_store)
            3'b101: begin
                st_data = {4{wdata[7:0]}};
                st_strb = 4'b0001 << offset;
            end
            3'b110: begin
                st_data = {2{wdata[15:0]}};
                st_strb = 4'b0011 << {offset[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        merged = data_mem[lat_index];
        for (int b = 0; b < 4; b++) begin
            if (lat_wstrb[b]) merged[8*b +: 8] = lat_wdata[8*b +: 8];
        end
    end

    // Stores take priority over loads; a load hit answers in the same cycle.
    always_comb begin
        state_nxt    = state;
        miss         = 1'b0;
        rdata        = '0;
        start_access = 1'b0;
        case (state)
            IDLE: begin
                if (memwrite) begin
                    miss         = 1'b1;
                    start_access = 1'b1;
                    state_nxt    = WR_WAIT;
                end else if (memread) begin
                    if (hit) begin
                        rdata = load_data;
                    end else begin
                        miss         = 1'b1;
                        start_access = 1'b1;
                        state_nxt    = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                miss = 1'b1;
                if (mem_ready) state_nxt = IDLE;
            end
            WR_WAIT: begin
                miss = 1'b1;
                if (mem_ready) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            valid_q   <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
        end else begin
            state <= state_nxt;
            if (start_access) begin
                lat_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                lat_wdata <= st_data;
                lat_wstrb <= st_strb;
            end
            if (state == RD_WAIT && mem_ready) valid_q[lat_index] <= 1'b1;
        end
    end

    // Line storage needs no reset: valid_q gates every use of it.
    always_ff @(posedge clk) begin
        if (state == RD_WAIT && mem_ready) begin
            tag_mem[lat_index]  <= lat_tag;
            data_mem[lat_index] <= mem_rdata;
        end else if (state == WR_WAIT && mem_ready && wr_hit) begin
            data_mem[lat_index] <= merged;
        end
    end

    assign mem_req   = (state == RD_WAIT) || (state == WR_WAIT);
    assign mem_we    = (state == WR_WAIT);
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign mem_wstrb = (state == WR_WAIT) ? lat_wstrb : 4'b0000;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a memory responder with adjustable latency,
// a request monitor, and one task per feature checking loads, stores and resets.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memread = 1'b0, memwrite = 1'b0;
    logic [2:0]  load_store = 3'b000;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        miss, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_t;

    req_t        exp_req_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] mem_model [1024];

    int checks = 0;
    int errors = 0;
    int latency = 1;
    int resp_cnt = 0;
    bit hold_ready = 1'b0;
    bit late_ready = 1'b0;

    dcache_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .INDEX_BITS(6)) dut (
        .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite),
        .load_store(load_store), .addr(addr), .wdata(wdata), .rdata(rdata),
        .miss(miss), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory responder: raises mem_ready after 'latency' request cycles.
    initial begin
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (late_ready) begin
                late_ready = 1'b0;
                mem_ready  = 1'b1;
                mem_rdata  = 32'hBAD0_BAD0;
            end else if (rst && mem_req && !hold_ready) begin
                resp_cnt++;
                if (resp_cnt >= latency) begin
                    resp_cnt  = 0;
                    mem_ready = 1'b1;
                    mem_rdata = mem_model[mem_addr[11:2]];
                    if (mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_wstrb[b]) mem_model[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                end
            end else begin
                resp_cnt = 0;
            end
        end
    end

    // Request monitor: every request cycle must match the expected transaction.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst && mem_req) begin
                checks++;
                if (exp_req_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_req got addr=%h we=%b expected none", mem_addr, mem_we);
                end else if (mem_we !== exp_req_q[0].we || mem_addr !== exp_req_q[0].addr ||
                             mem_wstrb !== exp_req_q[0].strb ||
                             (exp_req_q[0].we && mem_wdata !== exp_req_q[0].wdata)) begin
                    errors++;
                    $display("[TB] FAIL mem_req got we=%b addr=%h strb=%b wdata=%h expected we=%b addr=%h strb=%b wdata=%h",
                             mem_we, mem_addr, mem_wstrb, mem_wdata, exp_req_q[0].we,
                             exp_req_q[0].addr, exp_req_q[0].strb, exp_req_q[0].wdata);
                end
                if (mem_ready && exp_req_q.size() != 0) void'(exp_req_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic drive_load(input logic [2:0] ls, input logic [31:0] a,
                              output int stall, output logic [31:0] rd);
        bit done;
        done  = 1'b0;
        stall = 0;
        rd    = '0;
        memread = 1'b1; memwrite = 1'b0; load_store = ls; addr = a;
        while (!done) begin
            #1;
            if (!miss) begin
                rd   = rdata;
                done = 1'b1;
            end else begin
                stall++;
                if (stall > 50) begin
                    checks++; errors++;
                    $display("[TB] FAIL load_timeout addr=%h got miss=%b expected 0", a, miss);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        @(negedge clk);
        memread = 1'b0;
    endtask

    task automatic drive_store(input logic [2:0] ls, input logic [31:0] a, input logic [31:0] d,
                               input logic also_read, output int stall, output logic req_done);
        bit done;
        done     = 1'b0;
        stall    = 0;
        req_done = 1'b1;
        memread = also_read; memwrite = 1'b1; load_store = ls; addr = a; wdata = d;
        while (!done) begin
            #1;
            if (!miss) begin
                req_done = mem_req;
                done     = 1'b1;
            end else begin
                stall++;
                if (stall > 50) begin
                    checks++; errors++;
                    $display("[TB] FAIL store_timeout addr=%h got miss=%b expected 0", a, miss);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        @(negedge clk);
        memwrite = 1'b0; memread = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks += 7;
        if (mem_req !== 1'b0)   begin errors++; $display("[TB] FAIL reset_mem_req got %b expected 0", mem_req); end
        if (mem_we !== 1'b0)    begin errors++; $display("[TB] FAIL reset_mem_we got %b expected 0", mem_we); end
        if (mem_wstrb !== 4'h0) begin errors++; $display("[TB] FAIL reset_mem_wstrb got %b expected 0000", mem_wstrb); end
        if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr got %h expected 0", mem_addr); end
        if (mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_wdata got %h expected 0", mem_wdata); end
        if (miss !== 1'b0)      begin errors++; $display("[TB] FAIL reset_miss got %b expected 0", miss); end
        if (rdata !== 32'h0)    begin errors++; $display("[TB] FAIL reset_rdata got %h expected 0", rdata); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Load expectations go into exp_rd_q before the access and are popped on completion.
    task automatic test_load(input string name, input logic [2:0] ls, input logic [31:0] a,
                             input logic [31:0] exp_data, input int exp_stall);
        int stall;
        logic [31:0] rd, exp_v;
        exp_rd_q.push_back(exp_data);
        if (exp_stall != 0) exp_req_q.push_back('{we: 1'b0, addr: {a[31:2], 2'b00}, strb: 4'h0, wdata: 32'h0});
        drive_load(ls, a, stall, rd);
        exp_v = exp_rd_q.pop_front();
        checks += 2;
        if (rd !== exp_v) begin errors++; $display("[TB] FAIL %s_rdata got %h expected %h", name, rd, exp_v); end
        if (stall != exp_stall) begin errors++; $display("[TB] FAIL %s_stall got %0d expected %0d", name, stall, exp_stall); end
    endtask

    task automatic test_store(input string name, input logic [2:0] ls, input logic [31:0] a,
                              input logic [31:0] d, input logic also_read, input logic [31:0] exp_wdata,
                              input logic [3:0] exp_strb, input int exp_stall);
        int stall;
        logic req_done;
        exp_req_q.push_back('{we: 1'b1, addr: {a[31:2], 2'b00}, strb: exp_strb, wdata: exp_wdata});
        drive_store(ls, a, d, also_read, stall, req_done);
        checks += 3;
        if (stall != exp_stall) begin errors++; $display("[TB] FAIL %s_stall got %0d expected %0d", name, stall, exp_stall); end
        if (req_done !== 1'b0) begin errors++; $display("[TB] FAIL %s_done_req got %b expected 0", name, req_done); end
        if (exp_req_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_req_retired got %0d pending expected 0", name, exp_req_q.size());
            exp_req_q.delete();
        end
    endtask

    task automatic test_cold_load();
        latency = 3;
        test_load("cold_lw", 3'b100, 32'h100, 32'hDEAD_BEEF, 4);
        test_load("rehit_lw", 3'b100, 32'h100, 32'hDEAD_BEEF, 0);
    endtask

    task automatic test_extract();
        logic [2:0]  ls_t  [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b010, 3'b000, 3'b001, 3'b100};
        logic [31:0] a_t   [8] = '{32'h103, 32'h103, 32'h102, 32'h101, 32'h100, 32'h101, 32'h102, 32'h100};
        logic [31:0] exp_t [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
                                   32'h0000_7F01, 32'h0000_007F, 32'h0000_00FF, 32'h80FF_7F01};
        latency = 1;
        test_store("sw_hit", 3'b111, 32'h100, 32'h80FF_7F01, 1'b0, 32'h80FF_7F01, 4'b1111, 2);
        for (int i = 0; i < 8; i++) test_load($sformatf("extract%0d", i), ls_t[i], a_t[i], exp_t[i], 0);
    endtask

    task automatic test_partial_store();
        latency = 1;
        test_store("sb", 3'b101, 32'h101, 32'h0000_00AB, 1'b0, 32'hABAB_ABAB, 4'b0010, 2);
        test_load("sb_readback", 3'b100, 32'h100, 32'h80FF_AB01, 0);
        test_store("sh", 3'b110, 32'h103, 32'h0000_1234, 1'b0, 32'h1234_1234, 4'b1100, 2);
        test_load("sh_readback", 3'b100, 32'h100, 32'h1234_AB01, 0);
    endtask

    task automatic test_evict();
        latency = 2;
        test_load("conflict_lw", 3'b100, 32'h200, 32'h1111_2222, 3);
        test_load("conflict_hit", 3'b100, 32'h200, 32'h1111_2222, 0);
        test_load("evicted_lw", 3'b100, 32'h100, 32'h1234_AB01, 3);
    endtask

    task automatic test_no_allocate();
        latency = 2;
        test_store("sw_miss", 3'b111, 32'h200, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 4'b1111, 3);
        test_load("no_alloc_lw", 3'b100, 32'h200, 32'hCAFE_F00D, 3);
    endtask

    task automatic test_priority();
        latency = 1;
        test_store("rw_prio", 3'b111, 32'h204, 32'h5555_AAAA, 1'b1, 32'h5555_AAAA, 4'b1111, 2);
        test_load("prio_readback", 3'b100, 32'h204, 32'h5555_AAAA, 2);
    endtask

    task automatic test_reset_abort();
        int n;
        latency    = 1;
        hold_ready = 1'b1;
        exp_req_q.push_back('{we: 1'b0, addr: 32'h300, strb: 4'h0, wdata: 32'h0});
        memread = 1'b1; memwrite = 1'b0; load_store = 3'b100; addr = 32'h300;
        n = 0;
        while (mem_req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL abort_req_rise got %b expected 1", mem_req); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL abort_mem_req got %b expected 0", mem_req); end
        memread = 1'b0;
        exp_req_q.delete();
        hold_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #3;
        late_ready = 1'b1;
        @(negedge clk);
        #1;
        checks += 2;
        if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL late_ready_req got %b expected 0", mem_req); end
        if (miss !== 1'b0) begin errors++; $display("[TB] FAIL late_ready_miss got %b expected 0", miss); end
        @(negedge clk);
        test_load("post_reset_lw", 3'b100, 32'h200, 32'hCAFE_F00D, 2);
        test_load("aborted_addr_lw", 3'b100, 32'h300, 32'h3333_4444, 2);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_model[i] = 32'h0;
        mem_model[32'h100 >> 2] = 32'hDEAD_BEEF;
        mem_model[32'h200 >> 2] = 32'h1111_2222;
        mem_model[32'h300 >> 2] = 32'h3333_4444;
        repeat (3) @(negedge clk);
        test_reset();
        test_cold_load();
        test_extract();
        test_partial_store();
        test_evict();
        test_no_allocate();
        test_priority();
        test_reset_abort();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
